// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the two-requester bit-serial equality scheduler.
package serial_cmp_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/serial_eq_core.sv
// Bit-serial equality accumulator: clear presets the flag, each enabled cycle ANDs in X==Y.
module serial_eq_core (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic x,
  input  logic y,
  output logic eq,
  output logic eq_next
);

  logic eq_q;
  logic eq_d;

  // eq_next lets the caller latch the final result on the same edge as the last bit.
  assign eq_next = eq_q & (x == y);
  assign eq      = eq_q;

  always_comb begin
    // NOTE: defaulting every always_comb output first is what keeps this free of latches.
    eq_d = eq_q;
    if (clr) begin
      eq_d = 1'b1;
    end else if (en) begin
      eq_d = eq_next;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every flop so all state updates see pre-edge values.
    if (rst) begin
      eq_q <= 1'b1;
    end else begin
      eq_q <= eq_d;
    end
  end

endmodule

// File: rtl/serial_cmp_sched.sv
// Round-robin scheduler for two requesters sharing one LSB-first serial equality comparator.
module serial_cmp_sched
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             ACK0,
  output logic             ACK1,
  output logic             BUSY,
  output logic             X,
  output logic             Y,
  output logic             DONE,
  output logic             EQ,
  output logic             ID,
  output logic [7:0]       MATCH_CNT
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_out_q, eq_out_d;
  logic             id_q, id_d;
  logic [7:0]       mcnt_q, mcnt_d;
  logic             pick1;
  logic             eq_clr, eq_en, eq_flag, eq_next;

  serial_eq_core u_eq_core (
    .clk     (CLK),
    .rst     (RST),
    .clr     (eq_clr),
    .en      (eq_en),
    .x       (a_sh_q[0]),
    .y       (b_sh_q[0]),
    .eq      (eq_flag),
    .eq_next (eq_next)
  );

  // On a tie, grant whoever was not served last; last_q resets to 1 so requester 0 wins first.
  assign pick1 = REQ1 & (~REQ0 | ~last_q);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done_d   = 1'b0;
    eq_out_d = eq_out_q;
    id_d     = id_q;
    mcnt_d   = mcnt_q;
    eq_clr   = 1'b0;
    eq_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          a_sh_d  = pick1 ? A1 : A0;
          b_sh_d  = pick1 ? B1 : B0;
          gnt_d   = pick1;
          last_d  = pick1;
          ack0_d  = ~pick1;
          ack1_d  = pick1;
          cnt_d   = '0;
          eq_clr  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        eq_en  = 1'b1;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_RESULT;
          done_d   = 1'b1;
          eq_out_d = eq_next;
          id_d     = gnt_q;
          if (eq_next && (mcnt_q != 8'hFF)) begin
            mcnt_d = mcnt_q + 8'd1;
          end
        end
      end
      ST_RESULT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    // NOTE: shift registers are reset too: they drive X/Y directly, which must read 0 outside SHIFT.
    if (RST) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_out_q <= 1'b0;
      id_q     <= 1'b0;
      mcnt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      eq_out_q <= eq_out_d;
      id_q     <= id_d;
      mcnt_q   <= mcnt_d;
    end
  end

  // Shift registers are empty after WIDTH shifts, so bit 0 is naturally 0 outside SHIFT.
  assign X         = a_sh_q[0];
  assign Y         = b_sh_q[0];
  assign ACK0      = ack0_q;
  assign ACK1      = ack1_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign EQ        = eq_out_q;
  assign ID        = id_q;
  assign MATCH_CNT = mcnt_q;

endmodule

// File: tb/tb_serial_cmp_sched.sv
// Randomized self-checking bench for serial_cmp_sched against a transaction-level model.
module tb_serial_cmp_sched;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, busy, x, y, done, eq, id;
  logic [7:0]   match_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: who was granted last (1 after reset so requester 0 wins the first tie)
  int model_last = 1;
  int model_mcnt = 0;

  serial_cmp_sched #(.WIDTH(W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ0      (req0),
    .A0        (a0),
    .B0        (b0),
    .REQ1      (req1),
    .A1        (a1),
    .B1        (b1),
    .ACK0      (ack0),
    .ACK1      (ack1),
    .BUSY      (busy),
    .X         (x),
    .Y         (y),
    .DONE      (done),
    .EQ        (eq),
    .ID        (id),
    .MATCH_CNT (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".ack0"}, ack0, 0);
    check({tag, ".ack1"}, ack1, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".x"}, x, 0);
    check({tag, ".y"}, y, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check_quiet("rst");
    check("rst.eq", eq, 0);
    check("rst.id", id, 0);
    check("rst.mcnt", match_cnt, 0);
    rst = 1'b0;
    model_last = 1;
    model_mcnt = 0;
  endtask

  // One full transaction: inputs applied now, sampled at the next edge (E0).
  task automatic do_op(input bit r0, input bit r1,
                       input logic [W-1:0] a0_v, input logic [W-1:0] b0_v,
                       input logic [W-1:0] a1_v, input logic [W-1:0] b1_v,
                       input bit hold, input bit noise,
                       input bit chg_a0, input logic [W-1:0] a0_new);
    int g;
    logic [W-1:0] ea, eb;
    bit eq_exp;
    req0 = r0; req1 = r1;
    a0 = a0_v; b0 = b0_v; a1 = a1_v; b1 = b1_v;
    if (r0 && !r1)      g = 0;
    else if (r1 && !r0) g = 1;
    else                g = (model_last == 0) ? 1 : 0;
    model_last = g;
    ea = (g == 1) ? a1_v : a0_v;
    eb = (g == 1) ? b1_v : b0_v;
    eq_exp = (ea == eb);

    step();
    check("op.ack0", ack0, (g == 0));
    check("op.ack1", ack1, (g == 1));
    check("op.busy", busy, 1);
    check("op.x0", x, ea[0]);
    check("op.y0", y, eb[0]);
    if (!hold) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    for (int k = 1; k < W; k++) begin
      if (noise) begin
        req0 = 1'($urandom);
        req1 = 1'($urandom);
        a0 = W'($urandom); b0 = W'($urandom);
        a1 = W'($urandom); b1 = W'($urandom);
      end
      if (chg_a0 && k == 1) a0 = a0_new;
      step();
      check("shift.ack", {ack0, ack1}, 0);
      check("shift.done", done, 0);
      check("shift.busy", busy, 1);
      check("shift.x", x, ea[k]);
      check("shift.y", y, eb[k]);
    end
    if (noise) begin
      if (hold) begin
        req0 = r0; req1 = r1;
        a0 = a0_v; b0 = b0_v; a1 = a1_v; b1 = b1_v;
      end else begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    if (!hold) begin
      req0 = 1'b0; req1 = 1'b0;
    end

    step();
    check("res.done", done, 1);
    check("res.eq", eq, eq_exp);
    check("res.id", id, g);
    check("res.xy", {x, y}, 0);
    check("res.ack", {ack0, ack1}, 0);
    if (eq_exp && model_mcnt < 255) model_mcnt++;

    step();
    check("post.done", done, 0);
    check("post.busy", busy, 0);
    check("post.eq", eq, eq_exp);
    check("post.mcnt", match_cnt, model_mcnt);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    do_reset();
    repeat (3) begin
      step();
      check_quiet("idle");
    end

    // Equal operands on requester 0, then MSB-only mismatch on requester 1
    do_op(1, 0, 8'hA5, 8'hA5, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    check("a5.mcnt", match_cnt, 1);
    do_op(0, 1, 8'h00, 8'h00, 8'h80, 8'h00, 0, 0, 0, 8'h00);
    check("80.mcnt", match_cnt, 1);

    // Both requesters held: grants must alternate 0,1,0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_op(1, 1, 8'h12, 8'h12, 8'h34, 8'h35, 1, 0, 0, 8'h00);
      check("rr.id", id, (i % 2));
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    check_quiet("rr.end");

    // Reset during the 4th SHIFT cycle aborts the operation
    do_reset();
    req0 = 1'b1; a0 = 8'h55; b0 = 8'h55;
    step();
    check("abort.ack0", ack0, 1);
    req0 = 1'b0;
    repeat (3) step();
    check("abort.busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_last = 1;
    model_mcnt = 0;
    check_quiet("abort");
    check("abort.mcnt", match_cnt, 0);
    for (int i = 0; i < W + 2; i++) begin
      step();
      check("abort.nodone", {done, ack0, ack1, busy}, 0);
    end
    do_op(1, 0, 8'h5A, 8'h5A, 8'h00, 8'h00, 0, 0, 0, 8'h00);

    // Operand change after capture must not disturb the compare
    do_op(1, 0, 8'h0F, 8'h0F, 8'h00, 8'h00, 0, 0, 1, 8'hFF);
    check("chg.eq", eq, 1);

    // Randomized traffic with noise on inputs while busy and random idle gaps
    for (int i = 0; i < 150; i++) begin
      bit r0, r1, hold, noise;
      logic [W-1:0] va0, vb0, va1, vb1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      va0 = W'($urandom); va1 = W'($urandom);
      vb0 = ($urandom_range(0, 1) == 1) ? va0 : (va0 ^ W'(1 << $urandom_range(0, W - 1)));
      vb1 = ($urandom_range(0, 1) == 1) ? va1 : W'($urandom);
      hold  = 1'($urandom);
      noise = 1'($urandom);
      do_op(r0, r1, va0, vb0, va1, vb1, hold, noise, 0, 8'h00);
      if ($urandom_range(0, 3) == 0) begin
        req0 = 1'b0; req1 = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          step();
          check_quiet("gap");
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;

    // Saturation of the match counter
    do_reset();
    for (int i = 0; i < 260; i++) begin
      do_op(1, 0, 8'h3C, 8'h3C, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    end
    check("sat.mcnt", match_cnt, 255);
    do_op(0, 1, 8'h00, 8'h00, 8'h3C, 8'h3C, 0, 0, 0, 8'h00);
    check("sat.hold", match_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
